// File: rtl/adder_pkg.sv
// Shared helpers for the segmented adder: carry-segment bounds and widths.
package adder_pkg;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Lower bit index of segment k; segments past the top of the chain are empty.
  function automatic int seg_lo(input int width, input int stages, input int k);
    int lo;
    lo = k * ceil_div(width, stages);
    return (lo > width) ? width : lo;
  endfunction

  function automatic int seg_hi(input int width, input int stages, input int k);
    return seg_lo(width, stages, k + 1);
  endfunction

  function automatic int seg_width(input int width, input int stages, input int k);
    return seg_hi(width, stages, k) - seg_lo(width, stages, k);
  endfunction

endpackage

// File: rtl/adder_segment.sv
// One carry segment: a plain ripple add of W bits with carry in and carry out.
module adder_segment #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};

endmodule

// File: rtl/pipelined_unsigned_adder.sv
// Pipelined unsigned adder: the carry chain is cut into STAGES registered segments with a
// valid/ready handshake and bubble-collapsing per-stage valid bits.
module pipelined_unsigned_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH_A = 57,
  parameter int unsigned WIDTH_B = 57,
  parameter int unsigned STAGES  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_A-1:0] A,
  input  logic [WIDTH_B-1:0] B,
  input  logic               cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_A:0]   Sum
);

  logic [WIDTH_A-1:0] a_q   [STAGES];
  logic [WIDTH_A-1:0] b_q   [STAGES];
  logic [WIDTH_A-1:0] s_q   [STAGES];
  logic [WIDTH_A-1:0] a_src [STAGES];
  logic [WIDTH_A-1:0] b_src [STAGES];
  logic [WIDTH_A-1:0] s_src [STAGES];
  logic [WIDTH_A-1:0] s_nxt [STAGES];
  logic               c_nxt [STAGES];
  logic [STAGES-1:0]  c_q, v_q, c_src, v_src, load;
  logic [WIDTH_A-1:0] b_ext;
  logic               accept;

  if (WIDTH_B == WIDTH_A) begin : g_b_full
    assign b_ext = B;
  end else begin : g_b_zext
    assign b_ext = {{(WIDTH_A - WIDTH_B){1'b0}}, B};
  end

  // A stage may load when it is empty or its contents leave this cycle; walk from the output.
  always_comb begin
    logic free;
    free = out_ready;
    load = '0;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      load[k] = !v_q[k] || free;
      free    = load[k];
    end
  end

  assign in_ready  = !rst && load[0];
  assign accept    = in_valid && in_ready;
  assign out_valid = v_q[STAGES-1];
  assign Sum       = {c_q[STAGES-1], s_q[STAGES-1]};

  always_comb begin
    a_src[0] = A;
    b_src[0] = b_ext;
    s_src[0] = '0;
    c_src    = '0;
    v_src    = '0;
    c_src[0] = cin;
    v_src[0] = accept;
    for (int k = 1; k < int'(STAGES); k++) begin
      a_src[k] = a_q[k-1];
      b_src[k] = b_q[k-1];
      s_src[k] = s_q[k-1];
      c_src[k] = c_q[k-1];
      v_src[k] = v_q[k-1];
    end
  end

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
    localparam int Lo = seg_lo(WIDTH_A, STAGES, k);
    localparam int Hi = seg_hi(WIDTH_A, STAGES, k);
    localparam int W  = seg_width(WIDTH_A, STAGES, k);

    if (W > 0) begin : g_add
      logic [W-1:0] seg_s;

      adder_segment #(
        .W (W)
      ) u_seg (
        .a  (a_src[k][Hi-1:Lo]),
        .b  (b_src[k][Hi-1:Lo]),
        .ci (c_src[k]),
        .s  (seg_s),
        .co (c_nxt[k])
      );

      // Bits at and above Lo of the incoming partial sum are still zero.
      assign s_nxt[k] = s_src[k] | (WIDTH_A'(seg_s) << Lo);
    end else begin : g_pass
      assign s_nxt[k] = s_src[k];
      assign c_nxt[k] = c_src[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      c_q <= '0;
      for (int k = 0; k < int'(STAGES); k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(STAGES); k++) begin
        if (load[k]) begin
          v_q[k] <= v_src[k];
          if (v_src[k]) begin
            a_q[k] <= a_src[k];
            b_q[k] <= b_src[k];
            s_q[k] <= s_nxt[k];
            c_q[k] <= c_nxt[k];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_unsigned_adder.sv
// Randomized bench for pipelined_unsigned_adder: default build plus a parameter sweep,
// checked against plain-arithmetic sums and a queue of accepted operations.
module tb_pipelined_unsigned_adder;

  localparam int WA = 57;
  localparam int ST = 4;
  localparam int NSW = 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, cin, out_valid, out_ready;
  logic [WA-1:0] a, b;
  logic [WA:0]   sum;

  int total = 0;
  int bad   = 0;

  logic          obs_in_ready, obs_out_valid;
  logic [WA:0]   obs_sum;

  pipelined_unsigned_adder u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
    .B         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (sum)
  );

  // Sweep configurations (WIDTH_A, WIDTH_B, STAGES).
  function automatic int cfg_wa(input int g);
    case (g)
      0: return 8;
      1: return 57;
      2: return 57;
      default: return 64;
    endcase
  endfunction

  function automatic int cfg_wb(input int g);
    case (g)
      0: return 3;
      1: return 57;
      2: return 1;
      default: return 32;
    endcase
  endfunction

  function automatic int cfg_st(input int g);
    case (g)
      0: return 3;
      1: return 1;
      2: return 57;
      default: return 5;
    endcase
  endfunction

  logic        sw_iv  [4];
  logic        sw_ir  [4];
  logic        sw_cin [4];
  logic        sw_ov  [4];
  logic        sw_or  [4];
  logic [63:0] sw_a   [4];
  logic [63:0] sw_b   [4];
  logic [64:0] sw_sum [4];
  logic [64:0] sw_exp [4][NSW];

  for (genvar g = 0; g < 4; g++) begin : g_sw
    localparam int GWA = cfg_wa(g);
    localparam int GWB = cfg_wb(g);
    localparam int GST = cfg_st(g);
    logic [GWA:0] s;

    pipelined_unsigned_adder #(
      .WIDTH_A (GWA),
      .WIDTH_B (GWB),
      .STAGES  (GST)
    ) u_sw (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (sw_iv[g]),
      .in_ready  (sw_ir[g]),
      .A         (sw_a[g][GWA-1:0]),
      .B         (sw_b[g][GWB-1:0]),
      .cin       (sw_cin[g]),
      .out_valid (sw_ov[g]),
      .out_ready (sw_or[g]),
      .Sum       (s)
    );

    assign sw_sum[g] = 65'(s);
  end

  function automatic logic [WA:0] model(input logic [WA-1:0] x, input logic [WA-1:0] y,
                                        input logic c);
    return {1'b0, x} + {1'b0, y} + (WA + 1)'(c);
  endfunction

  function automatic logic [WA-1:0] rnd57();
    return WA'({$urandom(), $urandom()});
  endfunction

  // One clock cycle: drive mid-cycle, sample the settled state, then pass the rising edge.
  task automatic step(input logic iv, input logic [WA-1:0] ia, input logic [WA-1:0] ib,
                      input logic ic, input logic ordy);
    @(negedge clk);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    cin       = ic;
    out_ready = ordy;
    #1;
    obs_in_ready  = in_ready;
    obs_out_valid = out_valid;
    obs_sum       = sum;
    @(posedge clk);
  endtask

  // Issue one op into an idle pipe and count cycles until its result shows.
  task automatic run_single(input logic [WA-1:0] ia, input logic [WA-1:0] ib, input logic ic,
                            output logic [WA:0] res, output int lat, output logic acc);
    logic got;
    step(1'b1, ia, ib, ic, 1'b1);
    acc = obs_in_ready;
    lat = 0;
    got = 1'b0;
    res = '0;
    while (!got && lat < 20) begin
      step(1'b0, '0, '0, 1'b0, 1'b1);
      lat++;
      if (obs_out_valid) begin
        got = 1'b1;
        res = obs_sum;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    total++; if (sum !== '0) begin bad++; $display("FAIL reset_sum got=%h want=0", sum); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL release_out_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_full_ripple();
    logic [WA:0] res;
    int lat;
    logic acc;
    run_single({WA{1'b1}}, 57'd1, 1'b0, res, lat, acc);
    total++; if (acc !== 1'b1) begin bad++; $display("FAIL ripple_accept got=%b want=1", acc); end
    total++; if (lat != ST) begin bad++; $display("FAIL ripple_latency got=%0d want=%0d", lat, ST); end
    total++; if (res !== 58'h200_0000_0000_0000) begin bad++; $display("FAIL ripple_sum got=%h want=%h", res, 58'h200_0000_0000_0000); end
    step(1'b0, '0, '0, 1'b0, 1'b1);
    total++; if (obs_out_valid !== 1'b0) begin bad++; $display("FAIL ripple_single_result got=%b want=0", obs_out_valid); end
  endtask

  task automatic test_carry_in();
    logic [WA:0] res;
    int lat;
    logic acc;
    run_single('0, '0, 1'b1, res, lat, acc);
    total++; if (res !== 58'd1) begin bad++; $display("FAIL cin_only_sum got=%h want=1", res); end
    total++; if (lat != ST) begin bad++; $display("FAIL cin_only_latency got=%0d want=%0d", lat, ST); end
    run_single({WA{1'b1}}, {WA{1'b1}}, 1'b1, res, lat, acc);
    total++; if (res !== {(WA + 1){1'b1}}) begin bad++; $display("FAIL max_sum got=%h want=%h", res, {(WA + 1){1'b1}}); end
    total++; if (lat != ST) begin bad++; $display("FAIL max_latency got=%0d want=%0d", lat, ST); end
  endtask

  task automatic test_streaming();
    logic [WA:0] q[$];
    logic [WA-1:0] ra, rb;
    logic rc, iv, ev;
    for (int c = 0; c < 72; c++) begin
      iv = (c < 64);
      ra = rnd57();
      rb = rnd57();
      rc = 1'($urandom());
      step(iv, ra, rb, rc, 1'b1);
      if (iv) begin
        total++; if (obs_in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready cycle=%0d got=%b want=1", c, obs_in_ready); end
      end
      ev = (c >= ST) && (c < 64 + ST);
      total++; if (obs_out_valid !== ev) begin bad++; $display("FAIL stream_out_valid cycle=%0d got=%b want=%b", c, obs_out_valid, ev); end
      if (obs_out_valid && q.size() > 0) begin
        total++; if (obs_sum !== q[0]) begin bad++; $display("FAIL stream_sum cycle=%0d got=%h want=%h", c, obs_sum, q[0]); end
        void'(q.pop_front());
      end
      if (iv && obs_in_ready) q.push_back(model(ra, rb, rc));
    end
    total++; if (q.size() != 0) begin bad++; $display("FAIL stream_drain got=%0d want=0 left", q.size()); end
  endtask

  task automatic test_backpressure();
    logic [WA:0] q[$];
    logic [WA-1:0] ra, rb;
    logic rc, iv;
    int acc_stall = 0;
    int n_in = 0;
    int n_out = 0;
    for (int c = 0; c < 10; c++) begin
      ra = rnd57();
      rb = rnd57();
      rc = 1'($urandom());
      step(1'b1, ra, rb, rc, 1'b0);
      if (obs_out_valid && q.size() > 0) begin
        total++; if (obs_sum !== q[0]) begin bad++; $display("FAIL stall_sum_hold cycle=%0d got=%h want=%h", c, obs_sum, q[0]); end
      end
      if (obs_in_ready) begin
        acc_stall++;
        n_in++;
        q.push_back(model(ra, rb, rc));
      end
    end
    total++; if (acc_stall != ST) begin bad++; $display("FAIL stall_accepts got=%0d want=%0d", acc_stall, ST); end
    total++; if (obs_in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%b want=0", obs_in_ready); end
    total++; if (obs_out_valid !== 1'b1) begin bad++; $display("FAIL stall_out_valid got=%b want=1", obs_out_valid); end
    for (int c = 0; c < 24; c++) begin
      iv = (c < 8);
      ra = rnd57();
      rb = rnd57();
      rc = 1'($urandom());
      step(iv, ra, rb, rc, 1'b1);
      if (c == 0) begin
        total++; if (obs_in_ready !== 1'b1) begin bad++; $display("FAIL full_pipe_shift got=%b want=1", obs_in_ready); end
      end
      if (obs_out_valid) begin
        n_out++;
        if (q.size() == 0) begin
          total++; bad++; $display("FAIL release_extra_result got=%h want=none", obs_sum);
        end else begin
          total++; if (obs_sum !== q[0]) begin bad++; $display("FAIL release_sum cycle=%0d got=%h want=%h", c, obs_sum, q[0]); end
          void'(q.pop_front());
        end
      end
      if (iv && obs_in_ready) begin
        n_in++;
        q.push_back(model(ra, rb, rc));
      end
    end
    total++; if (n_out != n_in) begin bad++; $display("FAIL bp_count got=%0d want=%0d", n_out, n_in); end
    total++; if (n_in != ST + 8) begin bad++; $display("FAIL bp_accepts got=%0d want=%0d", n_in, ST + 8); end
  endtask

  task automatic test_reset_midstream();
    logic [WA:0] res;
    logic [WA-1:0] ra, rb;
    int lat;
    logic acc;
    int stale = 0;
    for (int c = 0; c < 3; c++) step(1'b1, rnd57(), rnd57(), 1'b1, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
    total++; if (sum !== '0) begin bad++; $display("FAIL midrst_sum got=%h want=0", sum); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL midrst_in_ready got=%b want=0", in_ready); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_release_ready got=%b want=1", in_ready); end
    for (int c = 0; c < 8; c++) begin
      step(1'b0, '0, '0, 1'b0, 1'b1);
      if (obs_out_valid) stale++;
    end
    total++; if (stale != 0) begin bad++; $display("FAIL midrst_stale got=%0d want=0", stale); end
    ra = rnd57();
    rb = rnd57();
    run_single(ra, rb, 1'b0, res, lat, acc);
    total++; if (lat != ST) begin bad++; $display("FAIL midrst_latency got=%0d want=%0d", lat, ST); end
    total++; if (res !== model(ra, rb, 1'b0)) begin bad++; $display("FAIL midrst_sum_after got=%h want=%h", res, model(ra, rb, 1'b0)); end
  endtask

  task automatic test_param_sweep();
    logic [64:0] amask, bmask;
    logic ev;
    int idx;
    for (int c = 0; c < NSW + 60; c++) begin
      @(negedge clk);
      for (int g = 0; g < 4; g++) begin
        amask = (65'd1 << cfg_wa(g)) - 65'd1;
        bmask = (65'd1 << cfg_wb(g)) - 65'd1;
        sw_iv[g]  = (c < NSW);
        sw_or[g]  = 1'b1;
        sw_a[g]   = {$urandom(), $urandom()} & amask[63:0];
        sw_b[g]   = {$urandom(), $urandom()} & bmask[63:0];
        sw_cin[g] = 1'($urandom());
        if (c < NSW) sw_exp[g][c] = {1'b0, sw_a[g]} + {1'b0, sw_b[g]} + 65'(sw_cin[g]);
      end
      #1;
      for (int g = 0; g < 4; g++) begin
        if (c < NSW) begin
          total++; if (sw_ir[g] !== 1'b1) begin bad++; $display("FAIL sweep%0d_in_ready cycle=%0d got=%b want=1", g, c, sw_ir[g]); end
        end
        idx = c - cfg_st(g);
        ev  = (idx >= 0) && (idx < NSW);
        total++; if (sw_ov[g] !== ev) begin bad++; $display("FAIL sweep%0d_out_valid cycle=%0d got=%b want=%b", g, c, sw_ov[g], ev); end
        if (ev) begin
          total++; if (sw_sum[g] !== sw_exp[g][idx]) begin bad++; $display("FAIL sweep%0d_sum op=%0d got=%h want=%h", g, idx, sw_sum[g], sw_exp[g][idx]); end
        end
      end
      @(posedge clk);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    out_ready = 1'b1;
    for (int g = 0; g < 4; g++) begin
      sw_iv[g]  = 1'b0;
      sw_or[g]  = 1'b1;
      sw_a[g]   = '0;
      sw_b[g]   = '0;
      sw_cin[g] = 1'b0;
    end
    test_reset();
    test_full_ripple();
    test_carry_in();
    test_streaming();
    test_backpressure();
    test_reset_midstream();
    test_param_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
